// File: rtl/sub_div_ctrl.sv
// Restoring unsigned 32-bit divider: one quotient bit per cycle through a single 32-bit subtractor.
// Optional macro SUB_DIV_ZERO_DETECT_EN: divide-by-zero is short-circuited to DONE with div_err=1.

module subtractor32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        cout
);
    // cout=1 means no borrow, i.e. a >= b
    assign {cout, result} = {1'b0, a} + {1'b0, ~b} + 33'd1;
endmodule

module sub_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] rem_reg, rem_next;
    logic [31:0] q_reg, q_next;
    logic [31:0] dvs_reg, dvs_next;
    logic [31:0] shifted, diff;
    logic        cout, take;

    assign shifted = {rem_reg[30:0], q_reg[31]};

    subtractor32 u_sub (
        .a      (shifted),
        .b      (dvs_reg),
        .result (diff),
        .cout   (cout)
    );

    // rem_reg[31] is the hidden 33rd bit of shifted: it then always exceeds the divisor
    assign take = rem_reg[31] | cout;

`ifdef SUB_DIV_ZERO_DETECT_EN
    logic err_reg, err_next;
    assign div_err = err_reg;
`else
    assign div_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
            rem_reg   <= 32'd0;
            q_reg     <= 32'd0;
            dvs_reg   <= 32'd0;
`ifdef SUB_DIV_ZERO_DETECT_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rem_reg   <= rem_next;
            q_reg     <= q_next;
            dvs_reg   <= dvs_next;
`ifdef SUB_DIV_ZERO_DETECT_EN
            err_reg   <= err_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        q_next      = q_reg;
        dvs_next    = dvs_reg;
        start_ready = 1'b0;
        done_valid  = 1'b0;
`ifdef SUB_DIV_ZERO_DETECT_EN
        err_next    = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    dvs_next = divisor;
`ifdef SUB_DIV_ZERO_DETECT_EN
                    if (divisor == 32'd0) begin
                        state_next = DONE;
                        q_next     = 32'hFFFF_FFFF;
                        rem_next   = dividend;
                        err_next   = 1'b1;
                    end else begin
                        state_next = RUN;
                        cnt_next   = 5'd31;
                        rem_next   = 32'd0;
                        q_next     = dividend;
                        err_next   = 1'b0;
                    end
`else
                    state_next = RUN;
                    cnt_next   = 5'd31;
                    rem_next   = 32'd0;
                    q_next     = dividend;
`endif
                end
            end
            RUN: begin
                rem_next = take ? diff : shifted;
                q_next   = {q_reg[30:0], take};
                cnt_next = cnt_reg - 5'd1;
                if (cnt_reg == 5'd0)
                    state_next = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign quotient  = q_reg;
    assign remainder = rem_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sub_div_ctrl.sv
// Directed bench for sub_div_ctrl: expected results queued at accept, checked when done_valid rises.
// Follows SUB_DIV_ZERO_DETECT_EN to choose the expected divide-by-zero latency and flag.

module tb_sub_div_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        done_valid;
    logic        done_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    sub_div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_err     (div_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, {31'd0, start_ready}, 32'd1);
        chk({tag, "_done_valid"},  {31'd0, done_valid},  32'd0);
        chk({tag, "_busy"},        {31'd0, busy},        32'd0);
        chk({tag, "_quotient"},    quotient,             32'd0);
        chk({tag, "_remainder"},   remainder,            32'd0);
        chk({tag, "_div_err"},     {31'd0, div_err},     32'd0);
    endtask

    // Called #1 after a rising edge while idle; returns #1 after the accept edge.
    task automatic start_op(input logic [31:0] dd, input logic [31:0] dv);
        exp_t e;
        if (dv == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = dd;
`ifdef SUB_DIV_ZERO_DETECT_EN
            e.err = 1'b1;
            e.lat = 1;
`else
            e.err = 1'b0;
            e.lat = 32;
`endif
        end else begin
            e.q   = dd / dv;
            e.r   = dd % dv;
            e.err = 1'b0;
            e.lat = 32;
        end
        sb.push_back(e);
        chk("pre_accept_start_ready", {31'd0, start_ready}, 32'd1);
        dividend    = dd;
        divisor     = dv;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        dividend    = $urandom;
        divisor     = $urandom;
        chk("post_accept_busy", {31'd0, busy}, 32'd1);
    endtask

    // Waits (bounded) for done_valid, then pops and compares one scoreboard entry.
    task automatic wait_result(input string tag);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (done_valid !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            dividend = $urandom;
            divisor  = $urandom;
        end
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"},   cycles,              e.lat);
            chk({tag, "_quotient"},  quotient,            e.q);
            chk({tag, "_remainder"}, remainder,           e.r);
            chk({tag, "_div_err"},   {31'd0, div_err},    {31'd0, e.err});
            $display("txn %s: q=%h r=%h err=%0b after %0d cycles", tag, quotient, remainder, div_err, cycles);
        end
    endtask

    // With done_ready high, the result leaves on the next edge and the block is idle again.
    task automatic handoff(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_handoff_done_valid"},  {31'd0, done_valid},  32'd0);
        chk({tag, "_handoff_start_ready"}, {31'd0, start_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] vec_dd [7];
        logic [31:0] vec_dv [7];
        logic [31:0] hold_q, hold_r;
        int          late_done;

        vec_dd = '{32'd100, 32'd5,  32'hFFFF_FFFF, 32'd15, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_002A};
        vec_dv = '{32'd7,   32'd10, 32'd1,         32'd15, 32'h8000_0000, 32'h8765_4321, 32'd0};

        rst         = 1'b1;
        start_valid = 1'b0;
        dividend    = 32'd0;
        divisor     = 32'd0;
        done_ready  = 1'b1;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("after_reset");

        for (int i = 0; i < 7; i++) begin
            start_op(vec_dd[i], vec_dv[i]);
            wait_result($sformatf("vec%0d", i));
            handoff($sformatf("vec%0d", i));
        end

        // Consumer stalls for 5 cycles; outputs hold and start requests are ignored.
        done_ready = 1'b0;
        start_op(32'd100, 32'd7);
        wait_result("stall");
        hold_q = quotient;
        hold_r = remainder;
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            dividend    = $urandom;
            divisor     = $urandom;
            @(posedge clk);
            #1;
            start_valid = (i == 4);
            chk("stall_done_valid",  {31'd0, done_valid},  32'd1);
            chk("stall_start_ready", {31'd0, start_ready}, 32'd0);
            chk("stall_quotient",    quotient,             hold_q);
            chk("stall_remainder",   remainder,            hold_r);
        end
        // start_valid stays high across the handoff edge and must not be accepted there.
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        chk("stall_release_done_valid",  {31'd0, done_valid},  32'd0);
        chk("stall_release_start_ready", {31'd0, start_ready}, 32'd1);
        chk("stall_release_busy",        {31'd0, busy},        32'd0);
        @(posedge clk);
        #1;
        chk("stall_no_accept_busy", {31'd0, busy}, 32'd0);

        // Abort mid-run: reset acts immediately, and no result ever appears.
        start_op(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        late_done = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (done_valid === 1'b1)
                late_done++;
        end
        chk("abort_no_done", late_done, 32'd0);
        void'(sb.pop_back());

        start_op(32'd100, 32'd7);
        wait_result("after_abort");
        handoff("after_abort");

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sub_div_ctrl.md
SUB_DIV_CTRL -- requirements
Module: sub_div_ctrl

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start_valid  input  1  requester presents an operand pair.
REQ-005 start_ready  output  1  block can accept an operand pair.
REQ-006 dividend  input  32  unsigned dividend, sampled on accept.
REQ-007 divisor  input  32  unsigned divisor, sampled on accept.
REQ-008 done_valid  output  1  quotient/remainder/div_err are valid.
REQ-009 done_ready  input  1  consumer takes the result.
REQ-010 quotient  output  32  unsigned quotient.
REQ-011 remainder  output  32  unsigned remainder.
REQ-012 div_err  output  1  divide-by-zero flag, valid with done_valid.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL sequence one instance of Subtractor32 (A - B; Cout=1 means no borrow, A>=B) to perform restoring unsigned division, one quotient bit per cycle.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; start_ready=1 only in IDLE; done_valid=1 only in DONE.
REQ-016 Accept SHALL occur on the edge where start_valid & start_ready; dividend and divisor are captured there and later input changes are ignored.
REQ-017 On accept (edge E), the FSM SHALL enter RUN with a 5-bit iteration counter = 31, partial remainder = 0, quotient register = dividend.
REQ-018 Each RUN edge SHALL form shifted = {rem[30:0], q[31]}, drive Subtractor32 A=shifted, B=divisor, and commit: if (rem[31] | Cout) then rem = Result and new q LSB = 1, else rem = shifted and new q LSB = 0; q shifts left by one.
REQ-019 The rem[31] term SHALL cover divisors above 2^31, where the 33-bit shifted value always exceeds the divisor and the wrapped 32-bit Result is correct.
REQ-020 The counter SHALL decrement each RUN edge; the edge processing counter==0 SHALL move to DONE, so done_valid rises at edge E+32.
REQ-021 In DONE, quotient, remainder and div_err SHALL hold stable until the edge where done_valid & done_ready, which returns the FSM to IDLE.
REQ-022 A new accept SHALL NOT occur in the same cycle as result handoff; the earliest next accept is the edge after return to IDLE.
REQ-023 start_valid asserted while busy SHALL be ignored with no effect.

Reset
REQ-024 rst high SHALL force IDLE immediately regardless of clk, aborting any division in progress with no result delivered.
REQ-025 Reset values: start_ready=1, done_valid=0, busy=0, quotient=0, remainder=0, div_err=0, counter=0.

Configuration
REQ-026 Macro SUB_DIV_ZERO_DETECT_EN defined: an accept with divisor==0 SHALL skip RUN and enter DONE at edge E+1 with quotient=FFFFFFFF, remainder=dividend, div_err=1.
REQ-027 Macro undefined: divisor==0 SHALL run the normal 32 iterations, giving quotient=FFFFFFFF and remainder=dividend at E+32; div_err SHALL be constant 0.

Verification
REQ-028 dividend=100, divisor=7, done_ready=1 -> done_valid at E+32, quotient=14, remainder=2, div_err=0.
REQ-029 5/10 -> quotient=0, remainder=5; FFFFFFFF/1 -> quotient=FFFFFFFF, remainder=0; 15/15 -> quotient=1, remainder=0.
REQ-030 FFFFFFFF/80000000 -> quotient=1, remainder=7FFFFFFF; 12345678/87654321 -> quotient=0, remainder=12345678 (exercises REQ-019).
REQ-031 dividend=0000002A, divisor=0 -> with macro: done_valid at E+1, div_err=1, quotient=FFFFFFFF, remainder=2A; without macro: done_valid at E+32, same values, div_err=0.
REQ-032 100/7 with done_ready held low 5 cycles after done_valid -> outputs stable, start_ready=0, start_valid pulses ignored; IDLE on the first edge with done_ready=1.
REQ-033 rst pulsed mid-RUN at E+10 -> outputs immediately at reset values, no done_valid; a following 100/7 accept completes normally with 14/2.
